// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: multiplexed hex driver for NUM_DIGITS common-anode 7-segment
// digits. Values are captured into a shadow register on load and copied to
// the display register only at frame boundaries, so a frame never tears.
// Each digit slot opens with BLANK_CYCLES of all-dark outputs (anti-ghosting).
// Optional feature macro: SEG7_LEADING_ZERO_BLANK_EN adds input lz_blank,
// which suppresses leading zero digits (digit 0 is always shown).
module seg7_scan_mux #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   digit_blank,
   input  logic                    load,
`ifdef SEG7_LEADING_ZERO_BLANK_EN
   input  logic                    lz_blank,
`endif
   output logic [6:0]              seg_n,
   output logic [NUM_DIGITS-1:0]   an_n,
   output logic                    frame_tick,
   output logic                    busy
);

   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int PW = $clog2(REFRESH_DIV);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
   localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

   // scan state
   logic [PW-1:0]           r_presc;
   logic [IW-1:0]           r_idx;
   // capture / display buffers
   logic [4*NUM_DIGITS-1:0] r_shadow_val;
   logic [NUM_DIGITS-1:0]   r_shadow_blank;
   logic [4*NUM_DIGITS-1:0] r_disp_val;
   logic [NUM_DIGITS-1:0]   r_disp_blank;
   logic                    r_pending;
   // registered outputs
   logic [6:0]              r_seg_n;
   logic [NUM_DIGITS-1:0]   r_an_n;
   logic                    r_frame_tick;

   logic                    w_slot_end;
   logic                    w_frame_end;
   logic                    w_dead;
   logic [3:0]              w_nib [NUM_DIGITS];
   logic [3:0]              w_cur_nib;
   logic [6:0]              w_seg_on;
   logic [NUM_DIGITS-1:0]   w_an_sel;
   logic [NUM_DIGITS-1:0]   w_eff_blank;

   assign w_slot_end  = (r_presc == PRESC_LAST);
   assign w_frame_end = w_slot_end && (r_idx == IDX_LAST);

   // Dead interval at the start of each slot; a zero-length interval needs no compare.
   generate
      if (BLANK_CYCLES == 0) begin : g_no_dead
         assign w_dead = 1'b0;
      end else begin : g_dead
         assign w_dead = (r_presc < PW'(BLANK_CYCLES));
      end
   endgenerate

   // Per-digit views of the display register and the one-hot anode select.
   generate
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         assign w_nib[gi]    = r_disp_val[4*gi +: 4];
         assign w_an_sel[gi] = (r_idx == IW'(gi));
      end
   endgenerate

   assign w_cur_nib = w_nib[r_idx];

`ifdef SEG7_LEADING_ZERO_BLANK_EN
   // A digit above 0 is a leading zero when it and every higher digit are zero.
   logic [NUM_DIGITS-1:0] w_dig_zero;
   logic [NUM_DIGITS-1:0] w_lz_sup;
   generate
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
         assign w_dig_zero[gi] = (w_nib[gi] == 4'h0);
         if (gi == 0) begin : g_lsd
            assign w_lz_sup[gi] = 1'b0;
         end else begin : g_upper
            assign w_lz_sup[gi] = &w_dig_zero[NUM_DIGITS-1:gi];
         end
      end
   endgenerate
   assign w_eff_blank = r_disp_blank | (w_lz_sup & {NUM_DIGITS{lz_blank}});
`else
   assign w_eff_blank = r_disp_blank;
`endif

   // Hex nibble to active-high segments, bit 6 = a ... bit 0 = g.
   always_comb begin
      w_seg_on = 7'b0000000;
      case (w_cur_nib)
         4'h0: w_seg_on = 7'b1111110;
         4'h1: w_seg_on = 7'b0110000;
         4'h2: w_seg_on = 7'b1101101;
         4'h3: w_seg_on = 7'b1111001;
         4'h4: w_seg_on = 7'b0110011;
         4'h5: w_seg_on = 7'b1011011;
         4'h6: w_seg_on = 7'b1011111;
         4'h7: w_seg_on = 7'b1110000;
         4'h8: w_seg_on = 7'b1111111;
         4'h9: w_seg_on = 7'b1111011;
         4'hA: w_seg_on = 7'b1110111;
         4'hB: w_seg_on = 7'b0011111;
         4'hC: w_seg_on = 7'b1001110;
         4'hD: w_seg_on = 7'b0111101;
         4'hE: w_seg_on = 7'b1001111;
         4'hF: w_seg_on = 7'b1000111;
         default: w_seg_on = 7'b0000000;
      endcase
   end

   // Refresh prescaler: counts cycles within one digit slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_presc <= '0;
      end else if (w_slot_end) begin
         r_presc <= '0;
      end else begin
         r_presc <= r_presc + 1'b1;
      end
   end

   // Digit index: advances at every slot end and wraps after the last digit.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx <= '0;
      end else if (w_slot_end) begin
         if (r_idx == IDX_LAST) begin
            r_idx <= '0;
         end else begin
            r_idx <= r_idx + 1'b1;
         end
      end
   end

   // Capture into shadow on load; commit shadow at the frame boundary.
   // A load coinciding with the commit is written after it, so the old shadow
   // is committed and the new value stays pending for the next frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_shadow_val   <= '0;
         r_shadow_blank <= '0;
         r_disp_val     <= '0;
         r_disp_blank   <= '0;
         r_pending      <= 1'b0;
      end else begin
         if (w_frame_end && r_pending) begin
            r_disp_val   <= r_shadow_val;
            r_disp_blank <= r_shadow_blank;
            r_pending    <= 1'b0;
         end
         if (load) begin
            r_shadow_val   <= value;
            r_shadow_blank <= digit_blank;
            r_pending      <= 1'b1;
         end
      end
   end

   // Frame tick: one-cycle pulse after the index wraps to 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_frame_tick <= 1'b0;
      end else begin
         r_frame_tick <= w_frame_end;
      end
   end

   // Output register: one cycle behind the scan state, dark in the dead interval.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_seg_n <= 7'b1111111;
         r_an_n  <= '1;
      end else if (w_dead) begin
         r_seg_n <= 7'b1111111;
         r_an_n  <= '1;
      end else begin
         r_seg_n <= ~w_seg_on;
         r_an_n  <= w_eff_blank[r_idx] ? '1 : ~w_an_sel;
      end
   end

   assign seg_n      = r_seg_n;
   assign an_n       = r_an_n;
   assign frame_tick = r_frame_tick;
   assign busy       = r_pending;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb_seg7_scan_mux: directed bench for seg7_scan_mux with a short refresh
// (4 digits, 8 cycles per slot, 2 dead cycles). Each frame is checked cycle
// by cycle against hand-computed segment patterns.
module tb_seg7_scan_mux;

   localparam int ND = 4;
   localparam int RD = 8;
   localparam int BC = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] value;
   logic [3:0]  digit_blank;
   logic        load;
   logic        lz_blank;
   logic [6:0]  seg_n;
   logic [3:0]  an_n;
   logic        frame_tick;
   logic        busy;

   int n_cmp = 0;
   int n_bad = 0;

   // load schedule for the frame being checked (-1 = unused entry)
   int          ld_m [2];
   logic [15:0] ld_v [2];
   logic [3:0]  ld_b [2];
   logic        exp_busy;

   seg7_scan_mux #(
      .NUM_DIGITS  (ND),
      .REFRESH_DIV (RD),
      .BLANK_CYCLES(BC)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .value      (value),
      .digit_blank(digit_blank),
      .load       (load),
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      .lz_blank   (lz_blank),
`endif
      .seg_n      (seg_n),
      .an_n       (an_n),
      .frame_tick (frame_tick),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic sched(input int k, input int m, input logic [15:0] v, input logic [3:0] b);
      ld_m[k] = m;
      ld_v[k] = v;
      ld_b[k] = b;
   endtask

   // Drive load before the edge following sample point m, if scheduled.
   task automatic drive_load(input int m);
      load = 1'b0;
      for (int k = 0; k < 2; k++) begin
         if (ld_m[k] == m) begin
            load        = 1'b1;
            value       = ld_v[k];
            digit_blank = ld_b[k];
         end
      end
   endtask

   // Checks one full frame of 32 cycles. Sample m follows edge m of the frame
   // and shows slot (m-1)/8, position (m-1)%8. frame_tick rises at m=32.
   task automatic check_frame(input string name,
                              input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3,
                              input logic [3:0] blk);
      logic [6:0] segs [4];
      segs[0] = s0;
      segs[1] = s1;
      segs[2] = s2;
      segs[3] = s3;
      drive_load(0);
      for (int m = 1; m <= 4*RD; m++) begin
         int s;
         int p;
         logic [3:0] exp_an;
         logic [6:0] exp_seg;
         @(negedge clk);
         s = (m - 1) / RD;
         p = (m - 1) % RD;
         if (m == 4*RD) exp_busy = 1'b0;
         for (int k = 0; k < 2; k++) begin
            if (ld_m[k] >= 0 && ld_m[k] == m - 1) exp_busy = 1'b1;
         end
         exp_an = 4'hF;
         if (p >= BC && !blk[s]) exp_an[s] = 1'b0;
         exp_seg = (p < BC) ? 7'h7F : segs[s];
         check($sformatf("%s m%0d an_n", name, m), {28'd0, an_n}, {28'd0, exp_an});
         check($sformatf("%s m%0d seg_n", name, m), {25'd0, seg_n}, {25'd0, exp_seg});
         check($sformatf("%s m%0d busy", name, m), {31'd0, busy}, {31'd0, exp_busy});
         check($sformatf("%s m%0d frame_tick", name, m), {31'd0, frame_tick},
               {31'd0, (m == 4*RD)});
         drive_load(m);
      end
      load = 1'b0;
      ld_m[0] = -1;
      ld_m[1] = -1;
   endtask

   // Reset held for 3 edges; outputs checked while in reset.
   task automatic do_reset(input string name);
      @(negedge clk);
      rst  = 1'b1;
      load = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check($sformatf("%s rst%0d seg_n", name, c), {25'd0, seg_n}, 32'h7F);
         check($sformatf("%s rst%0d an_n", name, c), {28'd0, an_n}, 32'hF);
         check($sformatf("%s rst%0d busy", name, c), {31'd0, busy}, 32'd0);
         check($sformatf("%s rst%0d frame_tick", name, c), {31'd0, frame_tick}, 32'd0);
      end
      rst      = 1'b0;
      exp_busy = 1'b0;
   endtask

   initial begin
      rst         = 1'b1;
      load        = 1'b0;
      value       = 16'h0000;
      digit_blank = 4'b0000;
      lz_blank    = 1'b0;
      exp_busy    = 1'b0;
      ld_m[0]     = -1;
      ld_m[1]     = -1;

      // Reset; first frame shows zeros and frame_tick arrives 32 cycles later.
      do_reset("reset");
      sched(0, 5, 16'h12AF, 4'b0000);
      check_frame("f0_zero", 7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001, 4'b0000);

      // 12AF shown; two loads mid-frame, last one wins.
      sched(0, 3, 16'h0000, 4'b0000);
      sched(1, 10, 16'h8888, 4'b0000);
      check_frame("f1_12AF", 7'b0111000, 7'b0001000, 7'b0010010, 7'b1001111, 4'b0000);

      // All eights, no intermediate zeros; queue blanking of digit 2.
      sched(0, 7, 16'h8888, 4'b0100);
      check_frame("f2_8888", 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 4'b0000);

      // Digit 2 dark; load 1234 then collide 5678 with the last slot end.
      sched(0, 5, 16'h1234, 4'b0000);
      sched(1, 4*RD - 1, 16'h5678, 4'b0000);
      check_frame("f3_blank", 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 4'b0100);

      // Old shadow (1234) committed; 5678 still pending for one more frame.
      check_frame("f4_1234", 7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111, 4'b0000);
      check_frame("f5_5678", 7'b0000000, 7'b0001111, 7'b0100000, 7'b0100100, 4'b0000);

      // Reset while a load is pending: the load is discarded.
      load  = 1'b1;
      value = 16'h9999;
      digit_blank = 4'b0000;
      @(negedge clk);
      load = 1'b0;
      check("midpend busy0", {31'd0, busy}, 32'd1);
      @(negedge clk);
      check("midpend busy1", {31'd0, busy}, 32'd1);
      do_reset("midpend");
      check_frame("f6_zero", 7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001, 4'b0000);
      check_frame("f7_zero", 7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001, 4'b0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
